// File: rtl/st_pkt_arbiter.sv
// Packet-atomic round-robin arbiter feeding one Avalon-ST sink from NUM_SRC sources.
// A grant is taken on a SOP beat in IDLE and held until the granted source's EOP transfers.
module st_pkt_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int DATA_W      = 16,
  parameter int CH_W        = 2,
  parameter int ENABLE_DROP = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC*2-1:0]      src_empty,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC-1:0]        src_startofpacket,
  input  logic [NUM_SRC-1:0]        src_endofpacket,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic [DATA_W-1:0]         data_out_data,
  output logic [1:0]                data_out_empty,
  output logic                      data_out_startofpacket,
  output logic                      data_out_endofpacket,
  output logic                      data_out_valid,
  input  logic                      data_out_ready,
  output logic [CH_W-1:0]           data_out_channel,
  output logic                      busy,
  output logic [15:0]               pkt_count,
  output logic [15:0]               drop_count
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state_reg, state_next;
  logic [CH_W-1:0] grant_reg, grant_next;
  logic [CH_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [15:0]     pkt_count_reg, pkt_count_next;
  logic [15:0]     drop_count_reg, drop_count_next;

  logic [NUM_SRC-1:0] request;
  logic [NUM_SRC-1:0] drop_beat;
  logic [CH_W-1:0]    pick;
  logic               pick_found;
  int                 off;
  int                 best_off;

  logic [DATA_W-1:0]  sel_data;
  logic [1:0]         sel_empty;
  logic               sel_valid, sel_sop, sel_eop;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_req
      assign request[gi]   = src_valid[gi] & src_startofpacket[gi];
      assign drop_beat[gi] = (ENABLE_DROP != 0) && src_valid[gi] && !src_startofpacket[gi];
    end
  endgenerate

  // Pick the requester with the smallest rotational distance from rr_ptr.
  always_comb begin
    pick       = '0;
    pick_found = |request;
    best_off   = NUM_SRC;
    off        = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (request[i]) begin
        off = (i >= int'(rr_ptr_reg)) ? i - int'(rr_ptr_reg) : i + NUM_SRC - int'(rr_ptr_reg);
        if (off < best_off) begin
          best_off = off;
          pick     = CH_W'(i);
        end
      end
    end
  end

  assign sel_data  = src_data[grant_reg*DATA_W +: DATA_W];
  assign sel_empty = src_empty[grant_reg*2 +: 2];
  assign sel_valid = src_valid[grant_reg];
  assign sel_sop   = src_startofpacket[grant_reg];
  assign sel_eop   = src_endofpacket[grant_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      rr_ptr_reg     <= '0;
      pkt_count_reg  <= '0;
      drop_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      rr_ptr_reg     <= rr_ptr_next;
      pkt_count_reg  <= pkt_count_next;
      drop_count_reg <= drop_count_next;
    end
  end

  always_comb begin
    state_next             = state_reg;
    grant_next             = grant_reg;
    rr_ptr_next            = rr_ptr_reg;
    pkt_count_next         = pkt_count_reg;
    drop_count_next        = drop_count_reg;
    src_ready              = '0;
    data_out_data          = '0;
    data_out_empty         = '0;
    data_out_startofpacket = 1'b0;
    data_out_endofpacket   = 1'b0;
    data_out_valid         = 1'b0;
    data_out_channel       = '0;
    busy                   = 1'b0;
    case (state_reg)
      IDLE: begin
        // SOP beats are never consumed here; only stray mid-packet beats are drained.
        src_ready = drop_beat;
        if ((|drop_beat) && (drop_count_reg != 16'hFFFF))
          drop_count_next = drop_count_reg + 16'd1;
        if (enable && pick_found) begin
          grant_next = pick;
          state_next = LOCK;
        end
      end
      LOCK: begin
        data_out_data          = sel_data;
        data_out_empty         = sel_empty;
        data_out_startofpacket = sel_sop;
        data_out_endofpacket   = sel_eop;
        data_out_valid         = sel_valid;
        data_out_channel       = grant_reg;
        busy                   = 1'b1;
        src_ready[grant_reg]   = data_out_ready;
        if (sel_valid && data_out_ready && sel_eop) begin
          pkt_count_next = pkt_count_reg + 16'd1;
          rr_ptr_next    = (grant_reg == CH_W'(NUM_SRC - 1)) ? '0 : grant_reg + 1'b1;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign pkt_count  = pkt_count_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_st_pkt_arbiter.sv
// Scoreboard bench for st_pkt_arbiter: per-source beat queues drive the inputs,
// expected output beats are queued in hand-chosen order and checked by a monitor.
module tb_st_pkt_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            enable = 1'b1;
  logic [N*DW-1:0] src_data;
  logic [N*2-1:0]  src_empty;
  logic [N-1:0]    src_valid, src_sop, src_eop, src_ready;
  logic [DW-1:0]   data_out_data;
  logic [1:0]      data_out_empty;
  logic            data_out_startofpacket, data_out_endofpacket, data_out_valid;
  logic            data_out_ready;
  logic [CW-1:0]   data_out_channel;
  logic            busy;
  logic [15:0]     pkt_count, drop_count;

  st_pkt_arbiter #(.NUM_SRC(N), .DATA_W(DW), .CH_W(CW), .ENABLE_DROP(1)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .src_data(src_data), .src_empty(src_empty), .src_valid(src_valid),
    .src_startofpacket(src_sop), .src_endofpacket(src_eop), .src_ready(src_ready),
    .data_out_data(data_out_data), .data_out_empty(data_out_empty),
    .data_out_startofpacket(data_out_startofpacket), .data_out_endofpacket(data_out_endofpacket),
    .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .data_out_channel(data_out_channel), .busy(busy),
    .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] data;
    logic [1:0]  empty;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t srcq[N][$];
  beat_t exp_q[$];
  bit    rdy_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    exp_pkt = 0;
  int    exp_drop = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t mk(input int s, input int k, input int n, input logic [15:0] base);
    beat_t b;
    b.ch    = 2'(s);
    b.data  = base + 16'(k);
    b.empty = (k == n - 1) ? 2'd1 : 2'd0;
    b.sop   = (k == 0);
    b.eop   = (k == n - 1);
    return b;
  endfunction

  task automatic send(input int s, input int n, input logic [15:0] base);
    for (int k = 0; k < n; k++) srcq[s].push_back(mk(s, k, n, base));
  endtask

  task automatic expect_pkt(input int s, input int n, input logic [15:0] base);
    for (int k = 0; k < n; k++) exp_q.push_back(mk(s, k, n, base));
    exp_pkt++;
  endtask

  task automatic drops(input int s, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b = mk(s, 1, 3, 16'hBAD0 + 16'(k));
      srcq[s].push_back(b);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  function automatic bit all_empty();
    bit e = (exp_q.size() == 0);
    for (int i = 0; i < N; i++) if (srcq[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic drain(input string name);
    int t;
    for (t = 0; t < 300; t++) begin
      step();
      if (all_empty()) break;
    end
    check(name, 32'(t < 300), 32'd1);
  endtask

  // Source driver: new inputs on the falling edge, handshakes sampled just before the rising edge.
  initial begin
    src_data = '0; src_empty = '0; src_valid = '0; src_sop = '0; src_eop = '0;
    data_out_ready = 1'b1;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (srcq[i].size() > 0) begin
          src_valid[i]          = 1'b1;
          src_data[i*DW +: DW]  = srcq[i][0].data;
          src_empty[i*2 +: 2]   = srcq[i][0].empty;
          src_sop[i]            = srcq[i][0].sop;
          src_eop[i]            = srcq[i][0].eop;
        end else begin
          src_valid[i]          = 1'b0;
          src_data[i*DW +: DW]  = '0;
          src_empty[i*2 +: 2]   = '0;
          src_sop[i]            = 1'b0;
          src_eop[i]            = 1'b0;
        end
      end
      data_out_ready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
      #4;
      for (int i = 0; i < N; i++)
        if (src_valid[i] && src_ready[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    end
  end

  // Monitor: compares every accepted output beat against the scoreboard head.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst && busy && exp_q.size() > 0)
        check("src_ready_mask", 32'(src_ready), data_out_ready ? (32'd1 << exp_q[0].ch) : 32'd0);
      if (!rst && data_out_valid && data_out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat: got data 0x%0h ch %0d expected no beat at %0t",
                   data_out_data, data_out_channel, $time);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 32'(data_out_data), 32'(e.data));
          check("beat_channel", 32'(data_out_channel), 32'(e.ch));
          check("beat_sop", 32'(data_out_startofpacket), 32'(e.sop));
          check("beat_eop", 32'(data_out_endofpacket), 32'(e.eop));
          check("beat_empty", 32'(data_out_empty), 32'(e.empty));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst = 1'b1;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(data_out_valid), 32'd0);
    check("rst_data", 32'(data_out_data), 32'd0);
    check("rst_channel", 32'(data_out_channel), 32'd0);
    check("rst_src_ready", 32'(src_ready), 32'd0);
    check("rst_pkt_count", 32'(pkt_count), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    rst = 1'b0;
    step();

    // All four sources request together: served 0,1,2,3.
    for (int s = 0; s < N; s++) send(s, 4, 16'((s + 1) * 16'h1000));
    for (int s = 0; s < N; s++) expect_pkt(s, 4, 16'((s + 1) * 16'h1000));
    drain("drain_rr");
    check("rr_pkt_count", 32'(pkt_count), 32'(exp_pkt));
    check("rr_drop_count", 32'(drop_count), 32'd0);

    // rr_ptr wrapped back to 0, so src0 beats src2.
    send(2, 3, 16'h2200);
    send(0, 3, 16'h2000);
    expect_pkt(0, 3, 16'h2000);
    expect_pkt(2, 3, 16'h2200);
    drain("drain_rr2");
    check("rr2_pkt_count", 32'(pkt_count), 32'(exp_pkt));

    // Single source, one-cycle arbitration latency.
    send(0, 6, 16'h0001);
    expect_pkt(0, 6, 16'h0001);
    step();
    check("lat_idle_busy", 32'(busy), 32'd0);
    check("lat_idle_valid", 32'(data_out_valid), 32'd0);
    step();
    check("lat_lock_busy", 32'(busy), 32'd1);
    check("lat_lock_valid", 32'(data_out_valid), 32'd1);
    check("lat_lock_data", 32'(data_out_data), 32'h0001);
    check("lat_lock_channel", 32'(data_out_channel), 32'd0);
    drain("drain_single");
    check("single_pkt_count", 32'(pkt_count), 32'(exp_pkt));

    // Backpressure on src1: ready 1,0,0,1 inside the packet.
    rdy_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    send(1, 4, 16'h3000);
    expect_pkt(1, 4, 16'h3000);
    drain("drain_bp");
    check("bp_pkt_count", 32'(pkt_count), 32'(exp_pkt));

    // Five stray non-SOP beats on src3 in IDLE are discarded.
    drops(3, 5);
    exp_drop = 5;
    drain("drain_drop");
    check("drop_count", 32'(drop_count), 32'(exp_drop));
    check("drop_pkt_count", 32'(pkt_count), 32'(exp_pkt));

    // enable=0 blocks a pending SOP; enable=1 grants it.
    enable = 1'b0;
    send(1, 2, 16'h4000);
    step();
    step();
    step();
    check("gate_busy", 32'(busy), 32'd0);
    check("gate_src_ready", 32'(src_ready), 32'd0);
    check("gate_pending", 32'(srcq[1].size()), 32'd2);
    enable = 1'b1;
    expect_pkt(1, 2, 16'h4000);
    drain("drain_gate");
    check("gate_pkt_count", 32'(pkt_count), 32'(exp_pkt));

    // Single-beat packet: busy for exactly one cycle.
    send(2, 1, 16'h5000);
    expect_pkt(2, 1, 16'h5000);
    step();
    check("sb_busy_before", 32'(busy), 32'd0);
    step();
    check("sb_busy_during", 32'(busy), 32'd1);
    check("sb_eop", 32'(data_out_endofpacket), 32'd1);
    step();
    check("sb_busy_after", 32'(busy), 32'd0);
    check("sb_pkt_count", 32'(pkt_count), 32'(exp_pkt));

    // Reset after two beats of a four-beat packet.
    send(0, 4, 16'h6000);
    exp_q.push_back(mk(0, 0, 4, 16'h6000));
    exp_q.push_back(mk(0, 1, 4, 16'h6000));
    for (t = 0; t < 50; t++) begin
      step();
      if (exp_q.size() == 0) break;
    end
    check("mid_rst_wait", 32'(t < 50), 32'd1);
    rst = 1'b1;
    srcq[0].delete();
    step();
    rst = 1'b0;
    exp_pkt = 0;
    exp_drop = 0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_src_ready", 32'(src_ready), 32'd0);
    check("mid_rst_valid", 32'(data_out_valid), 32'd0);
    check("mid_rst_pkt_count", 32'(pkt_count), 32'(exp_pkt));
    check("mid_rst_drop_count", 32'(drop_count), 32'(exp_drop));
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/st_pkt_arbiter.md
Name: st_pkt_arbiter

Overview:
- Packet-atomic round-robin arbiter sharing the single 16-bit Avalon-ST sink of the sts2stl 16-to-32-bit packer between NUM_SRC sensor streams.
- Grants one source per packet and locks the grant from startofpacket through endofpacket, so the packer never sees interleaved packets.
- Sits directly upstream of sts2stl; also reports the granted channel and per-arbiter packet and drop counters.

Parameters:
- NUM_SRC, 4, number of requesting Avalon-ST sources (2..8).
- DATA_W, 16, beat width in bits.
- CH_W, 2, width of channel index; must satisfy 2^CH_W >= NUM_SRC.
- ENABLE_DROP, 1, 1 = in IDLE, accept and discard valid beats without startofpacket; 0 = hold them off (ready=0).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  1 = new grants allowed; 0 = finish current packet, then grant nothing.
- src_data  in  NUM_SRC*DATA_W  source data; source i occupies bits [i*DATA_W +: DATA_W].
- src_empty  in  NUM_SRC*2  source empty; source i occupies [i*2 +: 2].
- src_valid  in  NUM_SRC  per-source valid.
- src_startofpacket  in  NUM_SRC  per-source SOP.
- src_endofpacket  in  NUM_SRC  per-source EOP.
- src_ready  out  NUM_SRC  per-source ready.
- data_out_data  out  DATA_W  to sts2stl data_in_data.
- data_out_empty  out  2  to sts2stl data_in_empty.
- data_out_startofpacket  out  1  SOP pass-through.
- data_out_endofpacket  out  1  EOP pass-through.
- data_out_valid  out  1  valid.
- data_out_ready  in  1  from sts2stl data_in_ready.
- data_out_channel  out  CH_W  index of the granted source; valid while locked.
- busy  out  1  1 while in LOCK.
- pkt_count  out  16  completed packets (EOP beats accepted), wraps at 0xFFFF->0.
- drop_count  out  16  discarded non-SOP beats in IDLE, saturates at 0xFFFF.

Behaviour:
- Avalon-ST semantics: readyLatency 0. A beat transfers on a rising clk edge when valid && ready.
- Reset (rst=1 at posedge):
  - state=IDLE; grant=0; rr_ptr=0 (source 0 highest priority).
  - pkt_count=0, drop_count=0, busy=0, data_out_channel=0.
  - While in IDLE, data_out_valid=0, src_ready=0 (except drop path), and data_out_data/empty/sop/eop are driven 0.
  - Reset mid-packet aborts the packet immediately; the downstream packer sees a truncated packet; no EOP is synthesized.
- State IDLE:
  - request[i] = src_valid[i] && src_startofpacket[i].
  - If enable && any request: grant = first requesting index searching rr_ptr, rr_ptr+1, ... mod NUM_SRC; register grant; go to LOCK.
  - No SOP beat is transferred in IDLE. Arbitration latency is one cycle from SOP valid to first possible transfer.
  - Drop path, if ENABLE_DROP=1: src_ready[i]=1 for every source with src_valid=1 and SOP=0; those beats are discarded and drop_count increments once per cycle when any such beat is present. Otherwise src_ready=0.
- State LOCK:
  - data_out_* = selected fields of source grant (combinational mux).
  - data_out_valid = src_valid[grant].
  - src_ready[grant] = data_out_ready; all other src_ready=0. No drops in LOCK.
  - busy=1; data_out_channel=grant.
  - On an accepted beat with EOP=1: pkt_count+1, rr_ptr = (grant+1) mod NUM_SRC, go to IDLE.
  - A single-beat packet (SOP and EOP on the same beat) completes in one LOCK cycle.
  - SOP seen again mid-packet from the granted source: forwarded unchanged; no re-arbitration.
  - enable is ignored in LOCK. Deasserting it mid-packet does not truncate the packet.
- Back-to-back packets: minimum 1 IDLE cycle between the EOP transfer and the next SOP transfer.
- Fairness: with all sources continuously requesting, the grant order is 0,1,2,3,0,...
- Counters update only on accepted beats, never when valid is held under backpressure.

Test Plan:
- Reset then idle: rst 2 cycles, no valid -> all outputs 0, busy=0, counters 0.
- Single source: src0 sends SOP beat 0x0001, beats 0x0002..0x0005, EOP on 0x0006, data_out_ready=1 -> 6 beats forwarded in order, channel=0, first transfer 1 cycle after SOP valid, pkt_count=1.
- Round-robin: sources 0..3 each present a 4-beat packet simultaneously -> packets out in order 0,1,2,3 with channel 0,1,2,3; no interleaving; pkt_count=4; then src2 and src0 request again -> src0 wins (rr_ptr=0).
- Backpressure: data_out_ready toggles 1,0,0,1 during a src1 packet -> src_ready[1] mirrors data_out_ready, no beat lost or duplicated, others' ready=0.
- Drop and gating: in IDLE, src3 valid without SOP for 5 cycles (ENABLE_DROP=1) -> drop_count=5; enable=0 with src1 SOP pending -> no grant; enable=1 -> grant to 1.
- Edge cases: single-beat packet (SOP+EOP) -> busy for exactly 1 cycle, pkt_count+1; rst asserted mid-packet -> next cycle IDLE, src_ready=0, data_out_valid=0, counters 0.
